// File: rtl/i2c_sensor_poller.sv
// i2c_sensor_poller: periodically sweeps up to N_CH I2C sensors through an external
// stream-style I2C master. For each enabled channel it writes the register pointer,
// reads NBYTES bytes, and queues one {channel, err, data} word in a show-ahead FIFO.
// A NAK still yields a word, with err=1 and data=0.
// Ports:
//   i_clk, i_rst (async, active high), i_fsm_rst (sync sweep abort), i_ch_en
//   master side: o_start, o_addr_*, o_nbytes_*, o_wdata_*, i_rdata_*, i_busy, i_nak
//   consumer side: o_sample/o_sample_valid/i_sample_ready, o_level, o_drop_cnt
module i2c_sensor_poller #(
  parameter int unsigned         N_CH        = 4,
  parameter int unsigned         NBYTES      = 2,
  parameter int unsigned         FIFO_AW     = 4,
  parameter int unsigned         POLL_PERIOD = 100000,
  parameter logic [7*N_CH-1:0]   CH_ADDR     = {N_CH{7'h27}},
  parameter logic [8*N_CH-1:0]   CH_REG      = {N_CH{8'h00}},
  localparam int unsigned        CHW         = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int unsigned        SW          = CHW + 1 + 8 * NBYTES
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fsm_rst,
  input  logic [N_CH-1:0]   i_ch_en,
  output logic              o_start,
  output logic [7:0]        o_addr_bits,
  output logic              o_addr_valid,
  input  logic              i_addr_ready,
  output logic [7:0]        o_nbytes_bits,
  output logic              o_nbytes_valid,
  input  logic              i_nbytes_ready,
  output logic [7:0]        o_wdata_bits,
  output logic              o_wdata_valid,
  input  logic              i_wdata_ready,
  input  logic [7:0]        i_rdata_bits,
  input  logic              i_rdata_valid,
  output logic              o_rdata_ready,
  input  logic              i_busy,
  input  logic              i_nak,
  output logic [SW-1:0]     o_sample,
  output logic              o_sample_valid,
  input  logic              i_sample_ready,
  output logic [FIFO_AW:0]  o_level,
  output logic [7:0]        o_drop_cnt
);

  localparam int unsigned DW    = 8 * NBYTES;
  localparam int unsigned CNTW  = $clog2(POLL_PERIOD);
  localparam int unsigned DEPTH = 2 ** FIFO_AW;

  typedef enum logic [3:0] {
    StIdle, StWStart, StWAddr, StWReg, StWWait, StRStart,
    StRAddr, StRNbytes, StRData, StRWait, StPush, StNext
  } state_e;

  state_e           r_state, w_state_d;
  logic [CHW-1:0]   r_ch, w_ch_d, w_ch_nxt;
  logic [CNTW-1:0]  r_cnt;
  logic             r_pend, r_err;
  logic [DW-1:0]    r_data;
  logic [1:0]       r_bcnt;
  logic             w_tick, w_xfer;
  logic [6:0]       w_addr7;

  logic [SW-1:0]    r_mem [DEPTH];
  logic [FIFO_AW:0] r_wptr, r_rptr, w_level;
  logic [SW-1:0]    w_word;
  logic             w_full, w_empty, w_push, w_pop, w_wr;
  logic [7:0]       r_drop;

  assign w_tick   = (r_cnt == CNTW'(POLL_PERIOD - 1));
  assign w_ch_nxt = r_ch + 1'b1;
  assign w_addr7  = CH_ADDR[7*r_ch +: 7];
  // States in which a NAK aborts the transaction (R_WAIT already waits for idle).
  assign w_xfer   = r_state inside {StWStart, StWAddr, StWReg, StWWait,
                                    StRStart, StRAddr, StRNbytes, StRData};

  assign o_addr_bits   = {w_addr7, (r_state == StRAddr)};
  assign o_nbytes_bits = 8'(NBYTES - 1);
  assign o_wdata_bits  = CH_REG[8*r_ch +: 8];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_d;
      r_ch    <= w_ch_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_ch_d         = r_ch;
    o_start        = 1'b0;
    o_addr_valid   = 1'b0;
    o_nbytes_valid = 1'b0;
    o_wdata_valid  = 1'b0;
    o_rdata_ready  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_tick || r_pend) begin
          w_ch_d    = '0;
          w_state_d = i_ch_en[0] ? StWStart : StNext;
        end
      end
      StWStart: begin
        o_start   = 1'b1;
        w_state_d = StWAddr;
      end
      StWAddr: begin
        o_addr_valid = 1'b1;
        if (i_addr_ready) w_state_d = StWReg;
      end
      StWReg: begin
        o_wdata_valid = 1'b1;
        if (i_wdata_ready) w_state_d = StWWait;
      end
      StWWait:  if (!i_busy) w_state_d = StRStart;
      StRStart: begin
        o_start   = 1'b1;
        w_state_d = StRAddr;
      end
      StRAddr: begin
        o_addr_valid = 1'b1;
        if (i_addr_ready) w_state_d = StRNbytes;
      end
      StRNbytes: begin
        o_nbytes_valid = 1'b1;
        if (i_nbytes_ready) w_state_d = StRData;
      end
      StRData: begin
        o_rdata_ready = 1'b1;
        if (i_rdata_valid && (r_bcnt == 2'(NBYTES - 1))) w_state_d = StRWait;
      end
      StRWait:  if (!i_busy) w_state_d = StPush;
      StPush:   w_state_d = StNext;
      StNext: begin
        if (r_ch == CHW'(N_CH - 1)) begin
          w_state_d = StIdle;
        end else begin
          w_ch_d    = w_ch_nxt;
          w_state_d = i_ch_en[w_ch_nxt] ? StWStart : StNext;
        end
      end
      default: w_state_d = StIdle;
    endcase
    // NAK: withdraw every request and let R_WAIT drain the master before the error push.
    if (w_xfer && i_nak) begin
      o_start        = 1'b0;
      o_addr_valid   = 1'b0;
      o_nbytes_valid = 1'b0;
      o_wdata_valid  = 1'b0;
      o_rdata_ready  = 1'b0;
      w_state_d      = StRWait;
    end
    if (i_fsm_rst) begin
      o_start        = 1'b0;
      o_addr_valid   = 1'b0;
      o_nbytes_valid = 1'b0;
      o_wdata_valid  = 1'b0;
      o_rdata_ready  = 1'b0;
      w_state_d      = StIdle;
      w_ch_d         = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_pend <= 1'b0;
      r_err  <= 1'b0;
      r_data <= '0;
      r_bcnt <= '0;
    end else begin
      if (i_fsm_rst) begin
        r_cnt  <= '0;
        r_pend <= 1'b0;
      end else begin
        r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        // Only one overrun tick is remembered; IDLE always consumes it.
        if (r_state == StIdle) r_pend <= 1'b0;
        else if (w_tick)       r_pend <= 1'b1;
      end
      if (r_state == StWStart) begin
        r_err  <= 1'b0;
        r_data <= '0;
        r_bcnt <= '0;
      end else if (o_rdata_ready && i_rdata_valid) begin
        r_data <= (r_data << 8) | DW'(i_rdata_bits);
        r_bcnt <= r_bcnt + 1'b1;
      end
      if ((w_xfer || r_state == StRWait) && i_nak) r_err <= 1'b1;
    end
  end

  // Sample FIFO: extra pointer bit distinguishes full from empty.
  assign w_level = r_wptr - r_rptr;
  assign w_full  = (w_level == (FIFO_AW + 1)'(DEPTH));
  assign w_empty = (w_level == '0);
  assign w_push  = (r_state == StPush) && !i_fsm_rst;
  assign w_pop   = !w_empty && i_sample_ready;
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_word  = {r_ch, r_err, (r_err ? {DW{1'b0}} : r_data)};

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr[FIFO_AW-1:0]] <= w_word;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_drop <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_wr && (r_drop != 8'hFF)) r_drop <= r_drop + 1'b1;
    end
  end

  assign o_sample       = w_empty ? '0 : r_mem[r_rptr[FIFO_AW-1:0]];
  assign o_sample_valid = !w_empty;
  assign o_level        = w_level;
  assign o_drop_cnt     = r_drop;

endmodule

// File: tb/tb_i2c_sensor_poller.sv
// Self-checking bench for i2c_sensor_poller: a behavioural I2C master/slave model
// answers the stream handshakes, a collector records popped samples, and directed
// vectors plus hand-written sequences cover NAK, overflow, overrun and resets.
module tb_i2c_sensor_poller;

  localparam int PERIOD = 60;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1, i_fsm_rst = 1'b0;
  logic [1:0]  i_ch_en = 2'b11;
  logic        o_start, o_addr_valid, o_nbytes_valid, o_wdata_valid, o_rdata_ready;
  logic [7:0]  o_addr_bits, o_nbytes_bits, o_wdata_bits;
  logic        i_addr_ready = 0, i_nbytes_ready = 0, i_wdata_ready = 0;
  logic [7:0]  i_rdata_bits = 0;
  logic        i_rdata_valid = 0, i_busy = 0, i_nak = 0;
  logic [17:0] o_sample;
  logic        o_sample_valid;
  logic        i_sample_ready = 1'b1;
  logic [2:0]  o_level;
  logic [7:0]  o_drop_cnt;

  i2c_sensor_poller #(
    .N_CH(2), .NBYTES(2), .FIFO_AW(2), .POLL_PERIOD(PERIOD),
    .CH_ADDR({2{7'h27}}), .CH_REG(16'h2010)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_fsm_rst(i_fsm_rst), .i_ch_en(i_ch_en),
    .o_start(o_start),
    .o_addr_bits(o_addr_bits), .o_addr_valid(o_addr_valid), .i_addr_ready(i_addr_ready),
    .o_nbytes_bits(o_nbytes_bits), .o_nbytes_valid(o_nbytes_valid),
    .i_nbytes_ready(i_nbytes_ready),
    .o_wdata_bits(o_wdata_bits), .o_wdata_valid(o_wdata_valid), .i_wdata_ready(i_wdata_ready),
    .i_rdata_bits(i_rdata_bits), .i_rdata_valid(i_rdata_valid), .o_rdata_ready(o_rdata_ready),
    .i_busy(i_busy), .i_nak(i_nak),
    .o_sample(o_sample), .o_sample_valid(o_sample_valid), .i_sample_ready(i_sample_ready),
    .o_level(o_level), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- slave / master model ----------------
  logic [7:0]  addr_log[$];
  logic [17:0] q[$];
  bit          nak_next = 0;
  int          stretch_once = 0;
  int          byte_gap = 0;
  logic [7:0]  last_reg = 8'h00;

  function automatic bit sig(input int which);
    case (which)
      0:       return o_addr_valid;
      1:       return o_wdata_valid;
      2:       return o_nbytes_valid;
      default: return o_rdata_ready;
    endcase
  endfunction

  task automatic wait_for(input int which, output bit ok);
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      if (sig(which)) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic serve();
    bit         ok;
    logic [7:0] a;
    logic [15:0] w;
    i_busy = 1;
    wait_for(0, ok);
    if (!ok) begin i_busy = 0; return; end
    a = o_addr_bits;
    addr_log.push_back(a);
    if (nak_next) begin
      nak_next = 0;
      i_nak = 1;
      repeat (3) @(negedge clk);
      i_nak = 0;
      i_busy = 0;
      return;
    end
    i_addr_ready = 1; @(negedge clk); i_addr_ready = 0;
    if (!a[0]) begin
      wait_for(1, ok);
      if (!ok) begin i_busy = 0; return; end
      last_reg = o_wdata_bits;
      i_wdata_ready = 1; @(negedge clk); i_wdata_ready = 0;
      i_busy = 0;
      return;
    end
    wait_for(2, ok);
    if (!ok) begin i_busy = 0; return; end
    check("nbytes_bits", 32'(o_nbytes_bits), 32'h1);
    i_nbytes_ready = 1; @(negedge clk); i_nbytes_ready = 0;
    w = (last_reg == 8'h20) ? 16'hABCD : 16'h1234;
    for (int i = 0; i < 2; i++) begin
      wait_for(3, ok);
      if (!ok) begin i_busy = 0; return; end
      repeat (byte_gap) @(negedge clk);
      i_rdata_bits = (i == 0) ? w[15:8] : w[7:0];
      i_rdata_valid = 1; @(negedge clk); i_rdata_valid = 0;
    end
    if (stretch_once > 0) begin
      repeat (stretch_once) @(negedge clk);
      stretch_once = 0;
    end
    i_busy = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (o_start && !i_rst) serve();
    end
  end

  // Collector: sample on the negedge before the popping posedge.
  always @(negedge clk) begin
    if (!i_rst && o_sample_valid && i_sample_ready) q.push_back(o_sample);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sync_sweep();
    @(negedge clk); i_fsm_rst = 1;
    @(negedge clk); i_fsm_rst = 0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #1; i_sample_ready = v;
  endtask

  typedef struct {
    logic [1:0]  en;
    bit          nak;
    int          n_smp;
    logic [17:0] smp0, smp1;
    int          n_addr;
    logic [7:0]  a_first, a_last;
  } vec_t;

  vec_t vecs[5];
  bit   ok;

  initial begin
    vecs[0] = '{2'b11, 0, 2, 18'h01234, 18'h2ABCD, 4, 8'h4E, 8'h4F};
    vecs[1] = '{2'b10, 0, 1, 18'h2ABCD, 18'h0,     2, 8'h4E, 8'h4F};
    vecs[2] = '{2'b11, 1, 2, 18'h10000, 18'h2ABCD, 3, 8'h4E, 8'h4F};
    vecs[3] = '{2'b00, 0, 0, 18'h0,     18'h0,     0, 8'h00, 8'h00};
    vecs[4] = '{2'b01, 0, 1, 18'h01234, 18'h0,     2, 8'h4E, 8'h4F};

    // Reset state
    wait_cyc(3);
    check("rst_start", 32'(o_start), 0);
    check("rst_addr_valid", 32'(o_addr_valid), 0);
    check("rst_rdata_ready", 32'(o_rdata_ready), 0);
    check("rst_sample_valid", 32'(o_sample_valid), 0);
    check("rst_sample", 32'(o_sample), 0);
    check("rst_level", 32'(o_level), 0);
    check("rst_drop", 32'(o_drop_cnt), 0);
    i_rst = 0;
    wait_cyc(2);

    // Table-driven sweeps
    for (int i = 0; i < 5; i++) begin
      i_ch_en  = vecs[i].en;
      nak_next = vecs[i].nak;
      q.delete();
      addr_log.delete();
      sync_sweep();
      wait_cyc(110);
      check($sformatf("v%0d_smp_count", i), 32'(q.size()), 32'(vecs[i].n_smp));
      if (vecs[i].n_smp > 0 && q.size() > 0)
        check($sformatf("v%0d_smp0", i), 32'(q[0]), 32'(vecs[i].smp0));
      if (vecs[i].n_smp > 1 && q.size() > 1)
        check($sformatf("v%0d_smp1", i), 32'(q[1]), 32'(vecs[i].smp1));
      check($sformatf("v%0d_addr_count", i), 32'(addr_log.size()), 32'(vecs[i].n_addr));
      if (vecs[i].n_addr > 0 && addr_log.size() > 0) begin
        check($sformatf("v%0d_addr_first", i), 32'(addr_log[0]), 32'(vecs[i].a_first));
        check($sformatf("v%0d_addr_last", i), 32'(addr_log[addr_log.size()-1]),
              32'(vecs[i].a_last));
      end
    end

    // Overrun: one long sweep swallows a tick -> exactly one back-to-back sweep
    i_ch_en = 2'b01;
    stretch_once = 80;
    q.delete();
    sync_sweep();
    wait_cyc(176);
    check("overrun_two_sweeps", 32'(q.size()), 2);
    wait_cyc(29);
    check("overrun_next_tick", 32'(q.size()), 3);
    i_ch_en = 2'b00;
    wait_cyc(20);

    // Overflow: consumer stalled for 6 single-channel sweeps
    set_ready(0);
    i_ch_en = 2'b01;
    q.delete();
    sync_sweep();
    wait_cyc(160);
    i_ch_en = 2'b10;
    wait_cyc(250);
    check("ovf_level", 32'(o_level), 4);
    check("ovf_drop", 32'(o_drop_cnt), 2);
    i_ch_en = 2'b00;
    set_ready(1);
    wait_cyc(10);
    check("ovf_drain_count", 32'(q.size()), 4);
    if (q.size() == 4) begin
      check("ovf_rd0", 32'(q[0]), 32'h01234);
      check("ovf_rd1", 32'(q[1]), 32'h01234);
      check("ovf_rd2", 32'(q[2]), 32'h2ABCD);
      check("ovf_rd3", 32'(q[3]), 32'h2ABCD);
    end
    check("ovf_level_empty", 32'(o_level), 0);

    // i_fsm_rst in the middle of R_DATA
    set_ready(0);
    i_ch_en = 2'b01;
    byte_gap = 0;
    sync_sweep();
    ok = 0;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      if (o_level == 3'd1) begin ok = 1; break; end
    end
    check("fsm_first_push", 32'(ok), 1);
    byte_gap = 10;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (o_rdata_ready) begin ok = 1; break; end
    end
    check("fsm_reach_rdata", 32'(ok), 1);
    i_fsm_rst = 1;
    #1;
    check("fsmrst_rdy_now", 32'(o_rdata_ready), 0);
    i_ch_en = 2'b00;
    @(negedge clk);
    i_fsm_rst = 0;
    #1;
    check("fsmrst_rdy_after", 32'(o_rdata_ready), 0);
    check("fsmrst_start_after", 32'(o_start), 0);
    wait_cyc(40);
    byte_gap = 0;
    check("fsmrst_level_kept", 32'(o_level), 1);
    check("fsmrst_drop_kept", 32'(o_drop_cnt), 2);
    check("fsmrst_sample_kept", 32'(o_sample), 32'h01234);

    // Asynchronous reset mid-sweep
    i_ch_en = 2'b01;
    sync_sweep();
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (o_addr_valid) begin ok = 1; break; end
    end
    check("rst_reach_addr", 32'(ok), 1);
    i_rst = 1;
    #1;
    check("arst_addr_valid", 32'(o_addr_valid), 0);
    check("arst_sample_valid", 32'(o_sample_valid), 0);
    check("arst_level", 32'(o_level), 0);
    check("arst_drop", 32'(o_drop_cnt), 0);
    check("arst_sample", 32'(o_sample), 0);
    i_ch_en = 2'b00;
    @(negedge clk);
    i_rst = 0;
    wait_cyc(40);
    check("arst_level_after", 32'(o_level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
